// File: rtl/zr_icb_pkg.sv
// ---------------------------------------------------------------------------
// zr_icb_pkg
// Shared ICB bus definitions: address/data/mask widths, the master-id type
// used to tag outstanding commands, and the arbiter lock-state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package zr_icb_pkg;

    localparam int unsigned ICB_AW = 32;
    localparam int unsigned ICB_DW = 32;
    localparam int unsigned ICB_MW = 4;

    // Identifies which requester issued a command.
    typedef logic icb_mid_t;

    localparam icb_mid_t MidM0 = 1'b0;
    localparam icb_mid_t MidM1 = 1'b1;

    // Arbiter grant state: free to re-arbitrate, or held on a stalled command.
    typedef enum logic {
        ArbFree,
        ArbLocked
    } arb_st_e;

    function automatic icb_mid_t other_mid(input icb_mid_t mid);
        return ~mid;
    endfunction

endpackage

// File: rtl/zr_icb_id_fifo.sv
// ---------------------------------------------------------------------------
// zr_icb_id_fifo
// Small in-order FIFO remembering which master owns each outstanding command.
// Pointers wrap modulo Depth; full/empty come from the registered count, so a
// pop in the current cycle never frees a slot for a push in the same cycle.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   push, wdata   enqueue request and data (ignored when full)
//   pop           dequeue request (ignored when empty)
//   rdata         entry at the head
//   count         number of valid entries
//   full, empty   status derived from count
// ---------------------------------------------------------------------------
module zr_icb_id_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (pop_ok) begin
            rptr_d = ptr_inc(rptr_q);
        end
        // Simultaneous push and pop leaves the count unchanged.
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/zr_icb_arb2.sv
// ---------------------------------------------------------------------------
// zr_icb_arb2
// Two-master to one-target ICB arbiter. Commands are forwarded with zero
// latency from the granted master; the owner of every accepted command is
// queued so responses are returned in order to their issuer.
//
// Parameters:
//   OUTS_DEPTH  maximum outstanding commands (1..8)
//   RR_EN       1 = round-robin, 0 = fixed priority with m0 highest
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   m0_icb_cmd_*         requester 0 (instruction fetch) command channel
//   m0_icb_rsp_*         requester 0 response channel
//   m1_icb_cmd_*         requester 1 (data bus) command channel
//   m1_icb_rsp_*         requester 1 response channel
//   s_icb_cmd_*          command channel towards the shared target
//   s_icb_rsp_*          response channel from the shared target
//   orphan_rsp_o         pulses when a response arrives with nothing outstanding
// ---------------------------------------------------------------------------
module zr_icb_arb2
    import zr_icb_pkg::*;
#(
    parameter int unsigned OUTS_DEPTH = 2,
    parameter int unsigned RR_EN      = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_icb_cmd_valid,
    output logic              m0_icb_cmd_ready,
    input  logic              m0_icb_cmd_read,
    input  logic [ICB_AW-1:0] m0_icb_cmd_addr,
    input  logic [ICB_DW-1:0] m0_icb_cmd_wdata,
    input  logic [ICB_MW-1:0] m0_icb_cmd_wmask,
    output logic              m0_icb_rsp_valid,
    input  logic              m0_icb_rsp_ready,
    output logic              m0_icb_rsp_err,
    output logic [ICB_DW-1:0] m0_icb_rsp_rdata,

    input  logic              m1_icb_cmd_valid,
    output logic              m1_icb_cmd_ready,
    input  logic              m1_icb_cmd_read,
    input  logic [ICB_AW-1:0] m1_icb_cmd_addr,
    input  logic [ICB_DW-1:0] m1_icb_cmd_wdata,
    input  logic [ICB_MW-1:0] m1_icb_cmd_wmask,
    output logic              m1_icb_rsp_valid,
    input  logic              m1_icb_rsp_ready,
    output logic              m1_icb_rsp_err,
    output logic [ICB_DW-1:0] m1_icb_rsp_rdata,

    output logic              s_icb_cmd_valid,
    input  logic              s_icb_cmd_ready,
    output logic              s_icb_cmd_read,
    output logic [ICB_AW-1:0] s_icb_cmd_addr,
    output logic [ICB_DW-1:0] s_icb_cmd_wdata,
    output logic [ICB_MW-1:0] s_icb_cmd_wmask,
    input  logic              s_icb_rsp_valid,
    output logic              s_icb_rsp_ready,
    input  logic              s_icb_rsp_err,
    input  logic [ICB_DW-1:0] s_icb_rsp_rdata,

    output logic              orphan_rsp_o
);

    localparam int unsigned CntW = $clog2(OUTS_DEPTH + 1);

    arb_st_e   st_q, st_d;
    icb_mid_t  lock_mid_q, lock_mid_d;
    icb_mid_t  prio_q, prio_d;
    icb_mid_t  gnt_mid;
    icb_mid_t  head_mid;
    logic      gnt_valid;
    logic      cmd_hs;
    logic      rsp_hs;
    logic      fifo_full;
    logic      fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic      unused_fifo_count;

    assign unused_fifo_count = ^fifo_count;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        gnt_mid = MidM0;
        if (st_q == ArbLocked) begin
            gnt_mid = lock_mid_q;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            gnt_mid = (RR_EN != 0) ? prio_q : MidM0;
        end else if (m1_icb_cmd_valid) begin
            gnt_mid = MidM1;
        end
    end

    assign gnt_valid = (gnt_mid == MidM1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;

    // ------------------------------------------------------------------
    // Command path
    // ------------------------------------------------------------------
    assign s_icb_cmd_valid  = ~rst & gnt_valid & ~fifo_full;
    assign m0_icb_cmd_ready = ~rst & (gnt_mid == MidM0) & s_icb_cmd_ready & ~fifo_full;
    assign m1_icb_cmd_ready = ~rst & (gnt_mid == MidM1) & s_icb_cmd_ready & ~fifo_full;
    assign cmd_hs           = s_icb_cmd_valid & s_icb_cmd_ready;

    always_comb begin
        s_icb_cmd_read  = m0_icb_cmd_read;
        s_icb_cmd_addr  = m0_icb_cmd_addr;
        s_icb_cmd_wdata = m0_icb_cmd_wdata;
        s_icb_cmd_wmask = m0_icb_cmd_wmask;
        if (gnt_mid == MidM1) begin
            s_icb_cmd_read  = m1_icb_cmd_read;
            s_icb_cmd_addr  = m1_icb_cmd_addr;
            s_icb_cmd_wdata = m1_icb_cmd_wdata;
            s_icb_cmd_wmask = m1_icb_cmd_wmask;
        end
    end

    // ------------------------------------------------------------------
    // Lock and round-robin state (next-state)
    // ------------------------------------------------------------------
    always_comb begin
        st_d       = st_q;
        lock_mid_d = lock_mid_q;
        prio_d     = prio_q;
        unique case (st_q)
            ArbFree: begin
                // An offered but stalled command pins the grant to its master.
                if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
                    st_d       = ArbLocked;
                    lock_mid_d = gnt_mid;
                end
            end
            ArbLocked: begin
                if (cmd_hs || !s_icb_cmd_valid) begin
                    st_d = ArbFree;
                end
            end
            default: st_d = ArbFree;
        endcase
        if (cmd_hs && (RR_EN != 0)) begin
            prio_d = other_mid(gnt_mid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ArbFree;
            lock_mid_q <= MidM0;
            prio_q     <= MidM0;
        end else begin
            st_q       <= st_d;
            lock_mid_q <= lock_mid_d;
            prio_q     <= prio_d;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-command tracking
    // ------------------------------------------------------------------
    zr_icb_id_fifo #(
        .Width (1),
        .Depth (OUTS_DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_hs),
        .wdata (gnt_mid),
        .pop   (rsp_hs),
        .rdata (head_mid),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Response path: only the head owner sees the response. With nothing
    // outstanding the response is accepted and dropped.
    // ------------------------------------------------------------------
    assign s_icb_rsp_ready = ~rst & (fifo_empty |
                             ((head_mid == MidM1) ? m1_icb_rsp_ready : m0_icb_rsp_ready));
    assign rsp_hs          = s_icb_rsp_valid & s_icb_rsp_ready & ~fifo_empty;
    assign orphan_rsp_o    = ~rst & s_icb_rsp_valid & fifo_empty;

    always_comb begin
        m0_icb_rsp_valid = 1'b0;
        m0_icb_rsp_err   = 1'b0;
        m0_icb_rsp_rdata = '0;
        m1_icb_rsp_valid = 1'b0;
        m1_icb_rsp_err   = 1'b0;
        m1_icb_rsp_rdata = '0;
        if (!rst && !fifo_empty) begin
            if (head_mid == MidM1) begin
                m1_icb_rsp_valid = s_icb_rsp_valid;
                m1_icb_rsp_err   = s_icb_rsp_err;
                m1_icb_rsp_rdata = s_icb_rsp_rdata;
            end else begin
                m0_icb_rsp_valid = s_icb_rsp_valid;
                m0_icb_rsp_err   = s_icb_rsp_err;
                m0_icb_rsp_rdata = s_icb_rsp_rdata;
            end
        end
    end

endmodule
